// File: rtl/vx_ram_pkg.sv
// Shared definitions for the single-port RAM controller: FSM state encodings
// and the read-credit rule that keeps the 2-entry response FIFO from overflowing.
package vx_ram_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // A read may issue if fewer than two responses are outstanding, or if one
  // leaves the FIFO in the same cycle.
  function automatic logic read_credit(input logic [1:0] fifo_count,
                                       input logic       pending,
                                       input logic       pop);
    logic [1:0] occ;
    occ = fifo_count + {1'b0, pending};
    return (occ < 2'd2) || pop;
  endfunction

endpackage

// File: rtl/vx_rsp_fifo2.sv
// Two-entry first-word-fall-through FIFO for read responses; head_data is
// valid whenever empty is low. Storage is not reset, only pointers and count.
module vx_rsp_fifo2 #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vx_sp_ram_ctrl.sv
// Requester-side controller for a single-port RAM with 1-cycle registered read:
// post-reset clear sweep, in-order tagged read responses, credit-checked buffering.
module vx_sp_ram_ctrl
  import vx_ram_pkg::*;
#(
  parameter int                 DATAW       = 32,
  parameter int                 SIZE        = 256,
  parameter int                 WRENW       = 4,
  parameter int                 TAGW        = 8,
  parameter bit                 INIT_ENABLE = 1'b1,
  parameter logic [DATAW-1:0]   INIT_VALUE  = '0,
  parameter int                 ADDRW       = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_rw,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [WRENW-1:0] req_wren,
  input  logic [DATAW-1:0] req_data,
  input  logic [TAGW-1:0]  req_tag,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [DATAW-1:0] rsp_data,
  output logic [TAGW-1:0]  rsp_tag,
  input  logic             rsp_ready,
  output logic             init_done,
  output logic             ram_reset,
  output logic             ram_read,
  output logic             ram_write,
  output logic [WRENW-1:0] ram_wren,
  output logic [ADDRW-1:0] ram_addr,
  output logic [DATAW-1:0] ram_wdata,
  input  logic [DATAW-1:0] ram_rdata
);

  typedef struct packed {
    logic [TAGW-1:0]  tag;
    logic [DATAW-1:0] data;
  } rsp_t;

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

  logic [0:0]       state;
  logic [ADDRW-1:0] init_cnt;
  logic             pending_p1;
  logic [TAGW-1:0]  tag_p1;
  rsp_t             push_rsp;
  rsp_t             head_rsp;
  logic [1:0]       fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             running;
  logic             rsp_pop;
  logic             rd_ready;
  logic             fire;

  assign ram_reset = reset;
  // Gate on reset so nothing is accepted or issued while reset is held.
  assign running   = (state == ST_RUN) & ~reset;
  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = head_rsp.data;
  assign rsp_tag   = head_rsp.tag;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rd_ready  = running & read_credit(fifo_count, pending_p1, rsp_pop);
  assign req_ready = req_rw ? running : rd_ready;
  assign fire      = req_valid & req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT_ENABLE ? ST_INIT : ST_RUN;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDRW'(1);
          if (init_cnt == LAST_ADDR) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: init_done <= 1'b1;
      endcase
    end
  end

  always_comb begin
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_wren  = req_wren;
    ram_addr  = req_addr;
    ram_wdata = req_data;
    if (state == ST_INIT) begin
      ram_write = ~reset;
      ram_wren  = '1;
      ram_addr  = init_cnt;
      ram_wdata = INIT_VALUE;
    end else if (fire) begin
      ram_write = req_rw;
      ram_read  = ~req_rw;
    end
  end

  // Stage p0 -> p1: read issued to RAM, tag held until rdata is valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_p1 <= 1'b0;
    else       pending_p1 <= fire & ~req_rw;
  end

  always_ff @(posedge clk) begin
    if (fire & ~req_rw) tag_p1 <= req_tag;
  end

  // Stage p1 -> p2: RAM data paired with its tag enters the response FIFO
  assign push_rsp.tag  = tag_p1;
  assign push_rsp.data = ram_rdata;

  vx_rsp_fifo2 #(
    .WIDTH (TAGW + DATAW)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pending_p1),
    .pop       (rsp_pop),
    .push_data (push_rsp),
    .head_data (head_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_full && pending_p1 && !rsp_pop));

endmodule

// File: tb/tb_vx_sp_ram_ctrl.sv
// Directed bench for vx_sp_ram_ctrl with a behavioural RAM macro (SIZE=16).
module tb_vx_sp_ram_ctrl;

  localparam int DATAW = 32;
  localparam int SIZE  = 16;
  localparam int WRENW = 4;
  localparam int TAGW  = 8;
  localparam int ADDRW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_rw;
  logic [ADDRW-1:0] req_addr;
  logic [WRENW-1:0] req_wren;
  logic [DATAW-1:0] req_data;
  logic [TAGW-1:0]  req_tag;
  logic             req_ready;
  logic             rsp_valid;
  logic [DATAW-1:0] rsp_data;
  logic [TAGW-1:0]  rsp_tag;
  logic             rsp_ready;
  logic             init_done;
  logic             ram_reset;
  logic             ram_read;
  logic             ram_write;
  logic [WRENW-1:0] ram_wren;
  logic [ADDRW-1:0] ram_addr;
  logic [DATAW-1:0] ram_wdata;
  logic [DATAW-1:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vx_sp_ram_ctrl #(
    .DATAW       (DATAW),
    .SIZE        (SIZE),
    .WRENW       (WRENW),
    .TAGW        (TAGW),
    .INIT_ENABLE (1'b1),
    .INIT_VALUE  (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wren  (req_wren),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_ready (rsp_ready),
    .init_done (init_done),
    .ram_reset (ram_reset),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_wren  (ram_wren),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Behavioural RAM macro: registered read, byte-lane writes
  logic [DATAW-1:0] mem [SIZE];
  always @(posedge clk) begin
    if (ram_reset)     ram_rdata <= '0;
    else if (ram_read) ram_rdata <= mem[ram_addr];
    if (ram_write) begin
      for (int l = 0; l < WRENW; l++)
        if (ram_wren[l]) mem[ram_addr][8*l +: 8] <= ram_wdata[8*l +: 8];
    end
  end

  typedef struct {
    logic             valid;
    logic             rw;
    logic [ADDRW-1:0] addr;
    logic [WRENW-1:0] wren;
    logic [DATAW-1:0] data;
    logic [TAGW-1:0]  tag;
    logic             rrdy;
    logic             exp_ready;
    logic             exp_rv;
    logic [DATAW-1:0] exp_data;
    logic [TAGW-1:0]  exp_tag;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic v, logic rw, logic [ADDRW-1:0] a, logic [WRENW-1:0] w,
                              logic [DATAW-1:0] d, logic [TAGW-1:0] t, logic rr,
                              logic er, logic ev, logic [DATAW-1:0] ed, logic [TAGW-1:0] et);
    vec_t r;
    r.valid = v; r.rw = rw; r.addr = a; r.wren = w; r.data = d; r.tag = t; r.rrdy = rr;
    r.exp_ready = er; r.exp_rv = ev; r.exp_data = ed; r.exp_tag = et;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [ADDRW-1:0] a,
                       input logic [WRENW-1:0] w, input logic [DATAW-1:0] d,
                       input logic [TAGW-1:0] t, input logic rr);
    req_valid = v; req_rw = rw; req_addr = a; req_wren = w; req_data = d; req_tag = t;
    rsp_ready = rr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic init_sweep();
    drive(1'b1, 1'b1, 4'd0, 4'hF, 32'hFFFF_FFFF, 8'h00, 1'b1);
    for (int i = 0; i < SIZE; i++) begin
      @(negedge clk);
      chk("init_write", 32'(ram_write), 32'd1);
      chk("init_addr", 32'(ram_addr), 32'(i));
      chk("init_wdata", ram_wdata, 32'h0);
      chk("init_wren", 32'(ram_wren), 32'hF);
      chk("init_req_ready", 32'(req_ready), 32'd0);
      chk("init_done_early", 32'(init_done), 32'd0);
    end
    @(negedge clk);
    chk("init_done", 32'(init_done), 32'd1);
    chk("post_init_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    next_cycle();
  endtask

  task automatic expect_rsp(input string name, input logic [DATAW-1:0] d, input logic [TAGW-1:0] t);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_data"}, rsp_data, d);
    chk({name, "_tag"}, 32'(rsp_tag), 32'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Table: write/read/partial-write, then 8 writes and an 8-read stream
    vecs[0] = mk(1, 1, 4'd5, 4'hF, 32'hAABBCCDD, 8'h00, 1, 1, 0, 32'h0, 8'h00);
    vecs[1] = mk(1, 0, 4'd5, 4'h0, 32'h0, 8'h11, 1, 1, 0, 32'h0, 8'h00);
    vecs[2] = mk(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1, 1, 0, 32'h0, 8'h00);
    vecs[3] = mk(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1, 1, 1, 32'hAABBCCDD, 8'h11);
    vecs[4] = mk(1, 1, 4'd5, 4'h5, 32'h11223344, 8'h00, 1, 1, 0, 32'h0, 8'h00);
    vecs[5] = mk(1, 0, 4'd5, 4'h0, 32'h0, 8'h22, 1, 1, 0, 32'h0, 8'h00);
    vecs[6] = mk(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1, 1, 0, 32'h0, 8'h00);
    vecs[7] = mk(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1, 1, 1, 32'hAA22CC44, 8'h22);
    for (int i = 0; i < 8; i++) begin
      vecs[8+i] = mk(1, 1, 4'(i), 4'hF, 32'hC0DE0000 | 32'(i), 8'h00, 1, 1, 0, 32'h0, 8'h00);
      vecs[16+i] = mk(1, 0, 4'(i), 4'h0, 32'h0, 8'(i), 1, 1, (i >= 2),
                      32'hC0DE0000 | 32'(i - 2), 8'(i - 2));
    end
    vecs[24] = mk(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1, 1, 1, 32'hC0DE0006, 8'd6);
    vecs[25] = mk(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1, 1, 1, 32'hC0DE0007, 8'd7);
    vecs[26] = mk(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1, 1, 0, 32'h0, 8'h00);

    reset = 1'b1;
    drive(1'b1, 1'b1, 4'd0, 4'hF, 32'h0, 8'h00, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_ram_write", 32'(ram_write), 32'd0);
      chk("rst_ram_read", 32'(ram_read), 32'd0);
    end
    next_cycle();
    reset = 1'b0;
    init_sweep();

    for (int k = 0; k < 27; k++) begin
      drive(vecs[k].valid, vecs[k].rw, vecs[k].addr, vecs[k].wren, vecs[k].data,
            vecs[k].tag, vecs[k].rrdy);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
      chk($sformatf("vec%0d_rsp_valid", k), 32'(rsp_valid), 32'(vecs[k].exp_rv));
      if (vecs[k].exp_rv) begin
        chk($sformatf("vec%0d_rsp_data", k), rsp_data, vecs[k].exp_data);
        chk($sformatf("vec%0d_rsp_tag", k), 32'(rsp_tag), 32'(vecs[k].exp_tag));
      end
      next_cycle();
    end

    // Backpressure: two reads fill the credit, reads stall, a write still flows
    drive(1, 0, 4'd1, 4'h0, 32'h0, 8'h30, 0);
    @(negedge clk); chk("bp_rd0_ready", 32'(req_ready), 32'd1); next_cycle();
    drive(1, 0, 4'd2, 4'h0, 32'h0, 8'h31, 0);
    @(negedge clk); chk("bp_rd1_ready", 32'(req_ready), 32'd1); next_cycle();
    drive(1, 0, 4'd3, 4'h0, 32'h0, 8'h32, 0);
    @(negedge clk); chk("bp_rd2_stall", 32'(req_ready), 32'd0);
    expect_rsp("bp_head0", 32'hC0DE0001, 8'h30); next_cycle();
    @(negedge clk); chk("bp_rd2_stall_full", 32'(req_ready), 32'd0); next_cycle();
    drive(1, 1, 4'd9, 4'hF, 32'h5555AAAA, 8'h00, 0);
    @(negedge clk);
    chk("bp_wr_ready", 32'(req_ready), 32'd1);
    chk("bp_wr_ram_write", 32'(ram_write), 32'd1);
    next_cycle();
    drive(1, 0, 4'd3, 4'h0, 32'h0, 8'h32, 0);
    @(negedge clk); chk("bp_rd2_still_stall", 32'(req_ready), 32'd0);
    expect_rsp("bp_head1", 32'hC0DE0001, 8'h30); next_cycle();
    rsp_ready = 1'b1;
    @(negedge clk); chk("bp_rd2_pop_ready", 32'(req_ready), 32'd1);
    expect_rsp("bp_drain0", 32'hC0DE0001, 8'h30); next_cycle();
    drive(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1);
    @(negedge clk); expect_rsp("bp_drain1", 32'hC0DE0002, 8'h31); next_cycle();
    @(negedge clk); expect_rsp("bp_drain2", 32'hC0DE0003, 8'h32); next_cycle();
    @(negedge clk); chk("bp_drained", 32'(rsp_valid), 32'd0); next_cycle();
    drive(1, 0, 4'd9, 4'h0, 32'h0, 8'h33, 1);
    @(negedge clk); chk("bp_rd9_ready", 32'(req_ready), 32'd1); next_cycle();
    drive(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1);
    @(negedge clk); chk("bp_rd9_wait", 32'(rsp_valid), 32'd0); next_cycle();
    @(negedge clk); expect_rsp("bp_rd9", 32'h5555AAAA, 8'h33); next_cycle();

    // Reset with two buffered responses
    drive(1, 0, 4'd4, 4'h0, 32'h0, 8'h40, 0);
    @(negedge clk); chk("rr_rd0_ready", 32'(req_ready), 32'd1); next_cycle();
    drive(1, 0, 4'd5, 4'h0, 32'h0, 8'h41, 0);
    @(negedge clk); chk("rr_rd1_ready", 32'(req_ready), 32'd1); next_cycle();
    drive(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 0);
    @(negedge clk); chk("rr_one_buffered", 32'(rsp_valid), 32'd1); next_cycle();
    @(negedge clk); expect_rsp("rr_two_buffered", 32'hC0DE0004, 8'h40);
    drive(1, 1, 4'd0, 4'hF, 32'h0, 8'h00, 0);
    reset = 1'b1;
    #1;
    chk("rr_rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("rr_req_ready", 32'(req_ready), 32'd0);
    chk("rr_ram_write", 32'(ram_write), 32'd0);
    @(posedge clk);
    next_cycle();
    reset = 1'b0;
    init_sweep();
    drive(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("rr_no_stale", 32'(rsp_valid), 32'd0); next_cycle();
    end
    drive(1, 0, 4'd5, 4'h0, 32'h0, 8'h50, 1);
    @(negedge clk); chk("rr_rd_ready", 32'(req_ready), 32'd1); next_cycle();
    drive(0, 0, 4'd0, 4'h0, 32'h0, 8'h00, 1);
    @(negedge clk); chk("rr_rd_wait", 32'(rsp_valid), 32'd0); next_cycle();
    @(negedge clk); expect_rsp("rr_cleared", 32'h0, 8'h50); next_cycle();
    @(negedge clk); chk("rr_idle", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
